instr_sequencer: RTL and testbench

Multi-cycle fetch/decode/execute controller for the cpu16 core, sitting directly upstream of the register file. It fetches 16-bit instructions over a single-outstanding memory handshake and decodes them. It drives the register file's read addresses, write port and PC count-enable, and computes results with a small ALU. r0 reads as zero, r7 is the PC.

---
 rtl/cpu16_pkg.sv | 38 +++
 rtl/alu.sv | 38 +++
 rtl/instr_sequencer.sv | 154 +++++++++++++++
 tb/tb_instr_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu16_pkg.sv
// cpu16 shared types: opcodes, sequencer states and instruction field slices.
package cpu16_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_SHR  = 4'h5,
        OP_LDI  = 4'h6,
        OP_ADDI = 4'h7,
        OP_LD   = 4'h8,
        OP_ST   = 4'h9,
        OP_BNZ  = 4'hA,
        OP_HALT = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        FETCH,
        WAIT_I,
        EXEC,
        MEM,
        WAIT_D,
        HALT
    } state_t;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RS1_MSB = 8;
    localparam int RS1_LSB = 6;
    localparam int RS2_MSB = 5;
    localparam int RS2_LSB = 3;
    localparam int IMM_MSB = 8;

endpackage

// File: rtl/alu.sv
// cpu16 combinational ALU: results for opcodes 0-7 and the BNZ branch target.
module alu
    import cpu16_pkg::*;
#(
    parameter int DataWidth = 16
) (
    input  opcode_t              op,
    input  logic [DataWidth-1:0] a,
    input  logic [DataWidth-1:0] b,
    input  logic [DataWidth-1:0] pc,
    input  logic [IMM_MSB:0]     imm,
    output logic [DataWidth-1:0] result,
    output logic [DataWidth-1:0] target
);

    logic [DataWidth-1:0] simm6;
    logic [DataWidth-1:0] zimm9;

    assign simm6  = {{(DataWidth-6){imm[5]}}, imm[5:0]};
    assign zimm9  = {{(DataWidth-IMM_MSB-1){1'b0}}, imm};
    assign target = pc + simm6;

    always_comb begin
        result = '0;
        unique case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SHR:  result = a >> 1;
            OP_LDI:  result = zimm9;
            OP_ADDI: result = a + simm6;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// cpu16 fetch/decode/execute sequencer driving the register file and memory port.
module instr_sequencer
    import cpu16_pkg::*;
#(
    parameter int DataWidth  = 16,
    parameter int NumRegs    = 8,
    parameter int IndexWidth = $clog2(NumRegs)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  memReqValid,
    input  logic                  memReqReady,
    output logic [DataWidth-1:0]  memAddr,
    output logic                  memWe,
    output logic [DataWidth-1:0]  memWData,
    input  logic                  memRespValid,
    input  logic [DataWidth-1:0]  memRData,
    output logic                  countEnable,
    output logic                  writeEnable,
    output logic [IndexWidth-1:0] writeAddr,
    output logic [DataWidth-1:0]  writeData,
    output logic [IndexWidth-1:0] readAddr1,
    output logic [IndexWidth-1:0] readAddr2,
    input  logic [DataWidth-1:0]  readData1,
    input  logic [DataWidth-1:0]  readData2,
    input  logic [DataWidth-1:0]  programCounter,
    output logic                  halted,
    output logic                  illegal
);

    localparam logic [IndexWidth-1:0] PcIdx = IndexWidth'(NumRegs - 1);

    state_t                state, state_next;
    logic [DataWidth-1:0]  ir;
    opcode_t               op;
    logic [IndexWidth-1:0] rd;
    logic [DataWidth-1:0]  alu_result;
    logic [DataWidth-1:0]  bnz_target;
    logic                  ir_load;
    logic                  set_halt;
    logic                  set_illegal;

    assign op        = opcode_t'(ir[OP_MSB:OP_LSB]);
    assign rd        = IndexWidth'(ir[RD_MSB:RD_LSB]);
    assign readAddr1 = IndexWidth'(ir[RS1_MSB:RS1_LSB]);
    assign readAddr2 = IndexWidth'(ir[RS2_MSB:RS2_LSB]);

    alu #(
        .DataWidth(DataWidth)
    ) u_alu (
        .op    (op),
        .a     (readData1),
        .b     (readData2),
        .pc    (programCounter),
        .imm   (ir[IMM_MSB:0]),
        .result(alu_result),
        .target(bnz_target)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= FETCH;
            ir      <= '0;
            halted  <= 1'b0;
            illegal <= 1'b0;
        end else begin
            state <= state_next;
            if (ir_load)     ir      <= memRData;
            if (set_halt)    halted  <= 1'b1;
            if (set_illegal) illegal <= 1'b1;
        end
    end

    // Strobes are gated by reset so nothing leaks out while rst is held low.
    always_comb begin
        state_next  = state;
        memReqValid = 1'b0;
        memAddr     = '0;
        memWe       = 1'b0;
        memWData    = '0;
        countEnable = 1'b0;
        writeEnable = 1'b0;
        writeAddr   = '0;
        writeData   = '0;
        ir_load     = 1'b0;
        set_halt    = 1'b0;
        set_illegal = 1'b0;
        if (rst) begin
            unique case (state)
                FETCH: begin
                    memReqValid = 1'b1;
                    memAddr     = programCounter;
                    if (memReqReady) state_next = WAIT_I;
                end
                WAIT_I: begin
                    if (memRespValid) begin
                        ir_load     = 1'b1;
                        countEnable = 1'b1;
                        state_next  = EXEC;
                    end
                end
                EXEC: begin
                    unique case (op)
                        OP_ADD, OP_SUB, OP_AND, OP_OR,
                        OP_XOR, OP_SHR, OP_LDI, OP_ADDI: begin
                            writeEnable = 1'b1;
                            writeAddr   = rd;
                            writeData   = alu_result;
                            state_next  = FETCH;
                        end
                        OP_LD, OP_ST: state_next = MEM;
                        OP_BNZ: begin
                            state_next = FETCH;
                            if (readData1 != '0) begin
                                writeEnable = 1'b1;
                                writeAddr   = PcIdx;
                                writeData   = bnz_target;
                            end
                        end
                        OP_HALT: begin
                            set_halt   = 1'b1;
                            state_next = HALT;
                        end
                        default: begin
                            set_halt    = 1'b1;
                            set_illegal = 1'b1;
                            state_next  = HALT;
                        end
                    endcase
                end
                MEM: begin
                    memReqValid = 1'b1;
                    memAddr     = readData1;
                    memWe       = (op == OP_ST);
                    memWData    = readData2;
                    if (memReqReady) state_next = WAIT_D;
                end
                WAIT_D: begin
                    if (memRespValid) begin
                        if (op == OP_LD) begin
                            writeEnable = 1'b1;
                            writeAddr   = rd;
                            writeData   = memRData;
                        end
                        state_next = FETCH;
                    end
                end
                HALT:    state_next = HALT;
                default: state_next = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with a small register-file model around it.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        memReqValid, memReqReady, memWe, memRespValid;
    logic [15:0] memAddr, memWData, memRData;
    logic        countEnable, writeEnable;
    logic [2:0]  writeAddr, readAddr1, readAddr2;
    logic [15:0] writeData, readData1, readData2, programCounter;
    logic        halted, illegal;
    logic [15:0] regs [8];
    int          checks = 0;
    int          errors = 0;

    logic [15:0] alu_ins [6] = '{16'h0A50, 16'h2A50, 16'h3A50,
                                 16'h4A50, 16'h5A80, 16'h7A7F};
    logic [15:0] alu_exp [6] = '{16'h0008, 16'h0001, 16'h0007,
                                 16'h0006, 16'h0002, 16'h0002};

    always #5 clk = ~clk;

    assign readData1      = regs[readAddr1];
    assign readData2      = regs[readAddr2];
    assign programCounter = regs[7];

    instr_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .memReqValid   (memReqValid),
        .memReqReady   (memReqReady),
        .memAddr       (memAddr),
        .memWe         (memWe),
        .memWData      (memWData),
        .memRespValid  (memRespValid),
        .memRData      (memRData),
        .countEnable   (countEnable),
        .writeEnable   (writeEnable),
        .writeAddr     (writeAddr),
        .writeData     (writeData),
        .readAddr1     (readAddr1),
        .readAddr2     (readAddr2),
        .readData1     (readData1),
        .readData2     (readData2),
        .programCounter(programCounter),
        .halted        (halted),
        .illegal       (illegal)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock; the register-file model applies the strobes seen before the edge.
    task automatic step();
        logic        we, ce;
        logic [2:0]  wa;
        logic [15:0] wd;
        we = writeEnable;
        ce = countEnable;
        wa = writeAddr;
        wd = writeData;
        @(posedge clk);
        #1;
        if (we) begin
            if (wa != 3'd0) regs[wa] = wd;
        end else if (ce) begin
            regs[7] = regs[7] + 16'd1;
        end
    endtask

    task automatic do_fetch(input logic [15:0] instr, input logic [15:0] addr);
        check("fetch_valid", memReqValid, 1);
        check("fetch_addr", memAddr, addr);
        check("fetch_we", memWe, 0);
        memReqReady = 1'b1;
        step();
        check("wait_i_ce_idle", countEnable, 0);
        memRespValid = 1'b1;
        memRData     = instr;
        #1;
        check("wait_i_ce", countEnable, 1);
        step();
        memRespValid = 1'b0;
        #1;
    endtask

    task automatic exec_write(input logic [15:0] instr, input logic [15:0] pc,
                              input logic [2:0] wa, input logic [15:0] wd);
        do_fetch(instr, pc);
        check("exec_we", writeEnable, 1);
        check("exec_wa", writeAddr, wa);
        check("exec_wd", writeData, wd);
        check("exec_ce", countEnable, 0);
        step();
    endtask

    initial begin
        for (int i = 0; i < 8; i++) regs[i] = 16'h0;
        memReqReady  = 1'b1;
        memRespValid = 1'b0;
        memRData     = 16'h0;
        rst          = 1'b0;
        step();
        step();
        check("rst_req", memReqValid, 0);
        check("rst_ce", countEnable, 0);
        check("rst_we", writeEnable, 0);
        check("rst_addr", memAddr, 0);
        check("rst_wa", writeAddr, 0);
        check("rst_wd", writeData, 0);
        check("rst_halted", halted, 0);
        check("rst_illegal", illegal, 0);
        rst = 1'b1;
        #1;

        exec_write(16'h6C2A, 16'd0, 3'd6, 16'h002A);
        check("ldi_r6", regs[6], 16'h002A);

        regs[1] = 16'd5;
        regs[2] = 16'd3;
        #1;
        exec_write(16'h1650, 16'd1, 3'd3, 16'h0002);
        regs[1] = 16'd3;
        regs[2] = 16'd5;
        #1;
        exec_write(16'h1650, 16'd2, 3'd3, 16'hFFFE);
        for (int i = 0; i < 6; i++)
            exec_write(alu_ins[i], 16'(3 + i), 3'd5, alu_exp[i]);

        regs[1] = 16'h0100;
        #1;
        do_fetch(16'h8840, 16'd9);
        check("ld_exec_we", writeEnable, 0);
        check("ld_exec_req", memReqValid, 0);
        step();
        check("ld_req", memReqValid, 1);
        check("ld_addr", memAddr, 16'h0100);
        check("ld_memwe", memWe, 0);
        step();
        memRespValid = 1'b1;
        memRData     = 16'hBEEF;
        #1;
        check("ld_we", writeEnable, 1);
        check("ld_wa", writeAddr, 4);
        check("ld_wd", writeData, 16'hBEEF);
        step();
        memRespValid = 1'b0;
        #1;

        exec_write(16'hA07E, 16'd10, 3'd7, 16'd9);

        regs[2] = 16'h1234;
        #1;
        do_fetch(16'h9050, 16'd9);
        step();
        check("st_req", memReqValid, 1);
        check("st_addr", memAddr, 16'h0100);
        check("st_memwe", memWe, 1);
        check("st_wdata", memWData, 16'h1234);
        step();
        memRespValid = 1'b1;
        #1;
        check("st_ack_we", writeEnable, 0);
        step();
        memRespValid = 1'b0;
        regs[1]      = 16'h0;
        #1;

        do_fetch(16'hA07E, 16'd10);
        check("bnz_nt_we", writeEnable, 0);
        step();

        memReqReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            memRespValid = (i == 2);
            #1;
            check("stall_valid", memReqValid, 1);
            check("stall_addr", memAddr, 16'd11);
            check("stall_ce", countEnable, 0);
            step();
        end
        memRespValid = 1'b0;
        memReqReady  = 1'b1;
        #1;
        exec_write(16'h6C2A, 16'd11, 3'd6, 16'h002A);

        do_fetch(16'hC000, 16'd12);
        check("ill_exec_we", writeEnable, 0);
        step();
        check("ill_halted", halted, 1);
        check("ill_illegal", illegal, 1);
        check("ill_req", memReqValid, 0);
        step();
        step();
        check("ill_req_held", memReqValid, 0);

        rst = 1'b0;
        step();
        rst = 1'b1;
        #1;
        check("rerst_halted", halted, 0);
        check("rerst_illegal", illegal, 0);

        regs[1] = 16'h0100;
        #1;
        do_fetch(16'h8840, 16'd13);
        step();
        step();
        rst          = 1'b0;
        memRespValid = 1'b1;
        memRData     = 16'hDEAD;
        #1;
        check("rst_wait_d_we", writeEnable, 0);
        step();
        rst         = 1'b1;
        memReqReady = 1'b0;
        #1;
        check("late_resp_we", writeEnable, 0);
        check("late_resp_ce", countEnable, 0);
        check("late_resp_req", memReqValid, 1);
        check("late_resp_addr", memAddr, 16'd14);
        step();
        memRespValid = 1'b0;
        memReqReady  = 1'b1;
        #1;

        do_fetch(16'hF000, 16'd14);
        check("halt_exec_we", writeEnable, 0);
        step();
        check("halt_halted", halted, 1);
        check("halt_illegal", illegal, 0);
        check("halt_req", memReqValid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
